// File: rtl/i2s_master_seq.sv
// i2s_master_seq: derives sck/ws from clk, frames 24-bit L/R slots, latches div/sel only at frame boundaries.
// Define I2S_FRAME_CNT_EN to implement frame_cnt; otherwise it is tied to zero.
module i2s_master_seq #(
    parameter int DIV_W     = 8,
    parameter int WORD_BITS = 24,
    parameter int FRAME_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DIV_W-1:0]   div,
    input  logic [1:0]         sel_in,
    output logic               sck_o,
    output logic               ws_o,
    output logic [1:0]         sel_o,
    output logic               frame_start,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam int BW = $clog2(WORD_BITS);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t           state_q;
    logic [DIV_W-1:0] div_q, div_cnt_q;
    logic [BW-1:0]    bit_cnt_q;
    logic             sck_q, ws_q, fs_q, busy_q;
    logic [1:0]       sel_q;
    logic             tc, fall, wrap, bnd, stop_end;
    assign tc       = div_cnt_q == div_q;
    assign fall     = tc && sck_q;
    assign wrap     = bit_cnt_q == BW'(WORD_BITS - 1);
    // sck is only ever high while running, so a falling toggle implies RUN or STOP
    assign bnd      = fall && wrap && ws_q;
    // a raised enable in STOP wins over returning to IDLE at the boundary
    assign stop_end = bnd && state_q == STOP && !enable;
    assign sck_o       = sck_q;
    assign ws_o        = ws_q;
    assign sel_o       = sel_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            sel_q     <= '0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            fs_q <= enable;
            if (enable) begin
                state_q   <= RUN;
                busy_q    <= 1'b1;
                div_q     <= div;
                sel_q     <= sel_in;
                div_cnt_q <= '0;
                bit_cnt_q <= '0;
            end
        end else begin
            div_cnt_q <= tc ? '0 : div_cnt_q + 1'b1;
            sck_q     <= tc ? ~sck_q : sck_q;
            bit_cnt_q <= fall ? (wrap ? '0 : bit_cnt_q + 1'b1) : bit_cnt_q;
            ws_q      <= (fall && wrap) ? ~ws_q : ws_q;
            state_q   <= stop_end ? IDLE : enable ? RUN : STOP;
            busy_q    <= !stop_end;
            fs_q      <= bnd && !stop_end;
            if (bnd && !stop_end) begin
                div_q <= div;
                sel_q <= sel_in;
            end
        end
    end
`ifdef I2S_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) frame_cnt_q <= '0;
        else if (bnd) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif
endmodule

// File: doc/i2s_master_seq.md
Name: i2s_master_seq

Overview:
Clock/frame sequencer for the two-channel I2S mixer datapath. Derives bit clock (sck) and word select (ws) from the system clock, frames the 24-bit left/right slots, and applies the mixer channel selection only at frame boundaries. Sits between the system-clock domain and the mixer; sck_o/ws_o/sel_o drive the mixer's sck/ws/channel_sel inputs.

Parameters:
DIV_W, 8, width of the clock divider setting
WORD_BITS, 24, sck cycles per half-frame (one channel slot)
FRAME_W, 16, width of frame counter

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  run request; level-sensitive
div  in  DIV_W  sck half-period = div+1 clk cycles
sel_in  in  2  requested channel_sel (00 none, 01 c1, 10 c2, 11 c1+c2)
sck_o  out  1  bit clock to mixer
ws_o  out  1  word select; 0 = left slot, 1 = right slot
sel_o  out  2  frame-stable channel_sel to mixer
frame_start  out  1  one-clk pulse at start of each left slot
busy  out  1  high in RUN or STOP
frame_cnt  out  FRAME_W  completed-frame count (optional feature)

Behaviour:
- Reset (sync, active-high, priority over everything): state=IDLE, sck_o=0, ws_o=0, sel_o=00, frame_start=0, busy=0, frame_cnt=0, internal div/bit counters=0, div_q=0.
- States: IDLE, RUN, STOP.
- IDLE: sck_o=0, ws_o=0. enable=1 -> RUN next cycle. On that transition: div_q<=div, sel_o<=sel_in, div/bit counters cleared, frame_start=1 for the first RUN cycle.
- Divider: counter counts 0..div_q. At terminal count sck_o toggles and counter returns to 0. sck high/low phases each div_q+1 clk. div=0 -> sck = clk/2. First sck rise comes div_q+1 clk after RUN entry.
- Bit counter: advances on each sck falling toggle, range 0..WORD_BITS-1. On wrap, ws_o toggles, coincident with the sck falling edge.
- Frame: 2*WORD_BITS sck periods, left slot (ws=0) then right slot (ws=1).
- Frame boundary: the falling toggle where ws_o goes 1->0. At a boundary in RUN:
  - frame_start=1 for that one clk cycle.
  - div_q<=div; sel_o<=sel_in. div/sel_in changes mid-frame are ignored.
  - frame_cnt increments and wraps at 2^FRAME_W.
- RUN with enable=0 -> STOP. The frame keeps running.
- STOP with enable=1 -> RUN with no glitch or counter change.
- STOP reaching a frame boundary -> IDLE. sck_o stays 0, ws_o=0, frame_cnt increments, no frame_start pulse, sel_o holds.
- If enable drops and rises in the same frame, the sequence is uninterrupted.
- busy = (state != IDLE), registered with state.
- Reset mid-frame: all outputs go to reset values at the next posedge. No partial-frame completion.
- sck_o and ws_o are registered outputs with no combinational path from inputs.

Optional Feature:
I2S_FRAME_CNT_EN
- Defined: frame_cnt implemented as above.
- Undefined: counter logic removed; frame_cnt tied to 0. All other behaviour is identical.

Test Plan:
- reset=1 for 3 clk, enable=1 during reset -> all outputs 0, state IDLE, busy=0 throughout.
- div=1, sel_in=11, enable=1, run 2 frames:
  - frame_start pulses at cycle 1 of RUN.
  - sck period 4 clk.
  - ws_o toggles every 96 clk, on sck falling edges.
  - frame_start repeats every 192 clk; frame_cnt=2 after 384 clk; sel_o=11.
- div=0 running, sel_in changes 01->10 mid-left-slot and div set to 3 -> sel_o and sck period (2 clk) unchanged until next boundary, then sel_o=10 and sck period 8 clk.
- enable=0 at ws=0 mid-frame -> busy stays 1. Frame completes, then sck_o/ws_o=0, busy=0, frame_cnt +1, no extra frame_start.
- enable 1->0->1 within one frame -> no change in sck/ws timing versus an uninterrupted run; busy stays 1.
- reset pulsed 1 clk mid-right-slot -> next cycle all outputs 0, IDLE. Re-enable restarts with ws=0 and a frame_start pulse; frame_cnt=0 (macro defined) / always 0 (macro undefined).
